// File: rtl/serial_pkg.sv
// Shared definitions for the single-wire serial link (receiver now, transmitter later).
package serial_pkg;

    localparam int DEF_MAX_BYTES = 6;   // default maximum bytes per frame
    localparam int DEF_CNT_W     = 6;   // default bit counter width, must hold 8*MAX_BYTES
    localparam int NB_W          = 3;   // width of the host frame-length field

    localparam logic START_BIT  = 1'b0;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    // Requested frame length limited to what the buffers can hold.
    function automatic logic [NB_W-1:0] clamp_nb(input logic [NB_W-1:0] req,
                                                 input int unsigned max_b);
        if (32'(req) > max_b) begin
            return NB_W'(max_b);
        end
        return req;
    endfunction

endpackage

// File: rtl/serial_rx_if.sv
// Host-side signal bundle of the serial receiver.
interface serial_rx_if;

    logic       rx;
    logic [2:0] nbytes;
    logic       get;
    logic       clr;
    logic [7:0] data;
    logic       valid;
    logic       done;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    // The receiver block itself.
    modport slave (
        input  rx, nbytes, get, clr,
        output data, valid, done, busy, frame_err, overrun
    );

    // The host / consumer driving the line and popping bytes.
    modport master (
        output rx, nbytes, get, clr,
        input  data, valid, done, busy, frame_err, overrun
    );

endinterface

// File: rtl/serial_rx_buf.sv
// Output byte buffer of the serial receiver: holds the last good frame and
// hands its bytes out one at a time through a get/valid pop port.
module serial_rx_buf
    import serial_pkg::*;
#(
    parameter int MAX_BYTES = DEF_MAX_BYTES
) (
    input  logic                   clk,
    input  logic                   nRst,
    input  logic                   commit,
    input  logic [8*MAX_BYTES-1:0] cap_data,
    input  logic [NB_W-1:0]        cap_nb,
    input  logic                   get,
    input  logic                   clr,
    output logic [7:0]             data,
    output logic                   valid,
    output logic                   overrun
);

    logic [MAX_BYTES-1:0][7:0] obuf;
    logic [NB_W-1:0]           rd_ptr;
    logic [NB_W-1:0]           avail;
    logic                      ovr_set;

    assign valid = (avail != '0);
    assign data  = valid ? obuf[rd_ptr] : '0;

    // A same-cycle get only rescues the last unread byte; anything more is lost.
    assign ovr_set = commit &&
                     ((avail > NB_W'(1)) || ((avail == NB_W'(1)) && !get));

    // Buffer load on commit, otherwise advance the read side on a valid pop.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            obuf   <= '0;
            rd_ptr <= '0;
            avail  <= '0;
        end else if (commit) begin
            obuf   <= cap_data;
            rd_ptr <= '0;
            avail  <= cap_nb;
        end else if (get && valid) begin
            rd_ptr <= rd_ptr + NB_W'(1);
            avail  <= avail - NB_W'(1);
        end
    end

    // Sticky overrun flag; a new event outranks a same-cycle clear.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            overrun <= 1'b0;
        end else if (ovr_set) begin
            overrun <= 1'b1;
        end else if (clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_rx.sv
// Receive end of the single-wire serial link: start bit, 8*N data bits LSB
// first, then a return-to-idle bit. Good frames are handed to the output buffer.
module serial_rx
    import serial_pkg::*;
#(
    parameter int MAX_BYTES = DEF_MAX_BYTES,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic      clk,
    input  logic      nRst,
    serial_rx_if.slave bus
);

    state_t                 state;
    logic [CNT_W-1:0]       bitcnt;
    logic [8*MAX_BYTES-1:0] cap;
    logic [NB_W-1:0]        nb;
    logic [NB_W-1:0]        nb_req;
    logic [CNT_W-1:0]       last_bit;
    logic                   done_q;
    logic                   ferr_q;
    logic                   commit;
    logic [7:0]             buf_data;
    logic                   buf_valid;
    logic                   buf_ovr;

    assign nb_req   = clamp_nb(bus.nbytes, MAX_BYTES);
    assign last_bit = CNT_W'({nb, 3'b000}) - CNT_W'(1);
    assign commit   = (state == STOP) && (bus.rx == IDLE_LEVEL);

    // Frame sequencer: start detect, bit capture, stop-bit check and flags.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state  <= IDLE;
            bitcnt <= '0;
            cap    <= '0;
            nb     <= '0;
            done_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.clr) begin
                ferr_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bus.rx == START_BIT) begin
                        nb     <= nb_req;
                        bitcnt <= '0;
                        state  <= (nb_req != '0) ? DATA : STOP;
                    end
                end
                DATA: begin
                    cap[bitcnt] <= bus.rx;
                    bitcnt      <= bitcnt + CNT_W'(1);
                    if (bitcnt == last_bit) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    // A low stop bit is an error, never a fresh start bit.
                    if (bus.rx == IDLE_LEVEL) begin
                        done_q <= 1'b1;
                    end else begin
                        ferr_q <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    serial_rx_buf #(
        .MAX_BYTES (MAX_BYTES)
    ) u_buf (
        .clk      (clk),
        .nRst     (nRst),
        .commit   (commit),
        .cap_data (cap),
        .cap_nb   (nb),
        .get      (bus.get),
        .clr      (bus.clr),
        .data     (buf_data),
        .valid    (buf_valid),
        .overrun  (buf_ovr)
    );

    assign bus.data      = buf_data;
    assign bus.valid     = buf_valid;
    assign bus.overrun   = buf_ovr;
    assign bus.done      = done_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx: directed frames from the test plan plus random frames,
// checked every cycle against a queue-based model of the unread bytes and flags.
module tb_serial_rx;

    logic clk = 1'b0;
    logic nRst;

    always #5 clk = ~clk;

    serial_rx_if bus();

    serial_rx #(
        .MAX_BYTES (6),
        .CNT_W     (6)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mq[$];   // model: unread bytes, head = current byte
    logic [7:0] fq[$];   // bytes to be sent in the next frame
    logic [7:0] cq[$];   // bytes a commit in this step delivers
    bit         m_ferr;
    bit         m_ovr;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_outputs(input bit eb, input bit ed);
        logic [7:0] exp_data;
        exp_data = (mq.size() != 0) ? mq[0] : 8'h00;
        chk("valid",     8'(bus.valid),     8'(mq.size() != 0));
        chk("data",      bus.data,          exp_data);
        chk("done",      8'(bus.done),      8'(ed));
        chk("busy",      8'(bus.busy),      8'(eb));
        chk("frame_err", 8'(bus.frame_err), 8'(m_ferr));
        chk("overrun",   8'(bus.overrun),   8'(m_ovr));
    endtask

    // One clock: apply inputs, let the edge happen, update the model, check.
    task automatic step(input bit r, input bit g, input bit c,
                        input bit commit_now, input bit bad_now, input bit eb);
        bit ovr_set;
        bus.rx  = r;
        bus.get = g;
        bus.clr = c;
        @(posedge clk);
        #1;
        ovr_set = commit_now && ((mq.size() > 1) || (mq.size() == 1 && !g));
        if (commit_now) begin
            mq = cq;
        end else if (g && mq.size() != 0) begin
            void'(mq.pop_front());
        end
        if (ovr_set) m_ovr = 1'b1;
        else if (c)  m_ovr = 1'b0;
        if (bad_now) m_ferr = 1'b1;
        else if (c)  m_ferr = 1'b0;
        bus.get = 1'b0;
        bus.clr = 1'b0;
        check_outputs(eb, commit_now);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        while (mq.size() != 0) pop();
    endtask

    task automatic fill_random(input int n);
        fq.delete();
        for (int i = 0; i < n; i++) fq.push_back(8'($urandom));
    endtask

    // Sends start, min(nb_req,6) bytes from fq LSB first, then the stop bit.
    // nbytes is scrambled after the start bit; the frame length must not follow it.
    task automatic send_frame(input int nb_req, input bit stop_v,
                              input bit g_commit, input bit c_commit);
        int         nbe;
        logic [7:0] fb[$];
        logic [7:0] cur;
        nbe = (nb_req > 6) ? 6 : nb_req;
        for (int i = 0; i < nbe; i++) fb.push_back(fq[i]);
        bus.nbytes = 3'(nb_req);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8 * nbe; i++) begin
            bus.nbytes = 3'($urandom);
            cur = fb[i / 8];
            step(cur[i % 8], 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        cq = fb;
        step(stop_v, g_commit, c_commit, stop_v, !stop_v, 1'b0);
    endtask

    initial begin
        bus.rx     = 1'b1;
        bus.get    = 1'b0;
        bus.clr    = 1'b0;
        bus.nbytes = 3'd0;
        m_ferr     = 1'b0;
        m_ovr      = 1'b0;
        nRst       = 1'b1;
        #1 nRst    = 1'b0;
        #11;
        check_outputs(1'b0, 1'b0);
        @(negedge clk) nRst = 1'b1;
        idle(2);

        // Two-byte frame, done at start+18, then pop both bytes.
        fq = '{8'hA5, 8'h3C};
        send_frame(2, 1'b1, 1'b0, 1'b0);
        pop();
        pop();
        idle(1);

        // Six bytes 0x01..0x06 popped in order.
        fq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_frame(6, 1'b1, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 6; i++) pop();

        // Bad stop bit leaves the held byte alone; clear; set-vs-clear.
        fq = '{8'h77};
        send_frame(1, 1'b1, 1'b0, 1'b0);
        fq = '{8'hFF};
        send_frame(1, 1'b0, 1'b0, 1'b0);
        idle(1);
        clear();
        send_frame(1, 1'b0, 1'b0, 1'b1);
        clear();
        drain();

        // Back-to-back frames without get overrun; with get on commit they do not.
        fq = '{8'h11};
        send_frame(1, 1'b1, 1'b0, 1'b0);
        fq = '{8'h22};
        send_frame(1, 1'b1, 1'b0, 1'b0);
        clear();
        drain();
        fq = '{8'h11};
        send_frame(1, 1'b1, 1'b0, 1'b0);
        fq = '{8'h22};
        send_frame(1, 1'b1, 1'b1, 1'b0);
        drain();

        // Zero-length frame, then nbytes=7 clamped to 6.
        fq.delete();
        send_frame(0, 1'b1, 1'b0, 1'b0);
        idle(1);
        fill_random(6);
        send_frame(7, 1'b1, 1'b0, 1'b0);
        idle(1);
        drain();

        // Reset during byte 1 of a 3-byte frame while bytes and overrun are held.
        fill_random(3);
        send_frame(3, 1'b1, 1'b0, 1'b0);
        fq = '{8'h44};
        send_frame(1, 1'b1, 1'b0, 1'b0);
        bus.nbytes = 3'd3;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) step(1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.rx = 1'b1;
        nRst   = 1'b0;
        #2;
        mq.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        check_outputs(1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_outputs(1'b0, 1'b0);
        @(negedge clk) nRst = 1'b1;
        fq = '{8'h5A};
        send_frame(1, 1'b1, 1'b0, 1'b0);
        pop();

        // Random frames with random gaps, pops and clears.
        for (int k = 0; k < 30; k++) begin
            int nb;
            int gap;
            nb = $urandom_range(0, 7);
            fill_random(6);
            send_frame(nb, ($urandom_range(0, 5) != 0), 1'($urandom), ($urandom_range(0, 3) == 0));
            gap = $urandom_range(0, 3);
            for (int j = 0; j < gap; j++) begin
                step(1'b1, 1'($urandom), ($urandom_range(0, 3) == 0), 1'b0, 1'b0, 1'b0);
            end
        end
        drain();
        clear();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
